// File: rtl/noc_wormhole_arbiter.sv
// Per-output-port wormhole arbiter: locks the output to one input for a whole packet,
// counts its flits, releases on the last flit or a tail flit, and rotates priority round-robin.
module noc_wormhole_arbiter #(
  parameter int                   NUM_IN    = 5,
  parameter int                   LEN_WIDTH = 12,
  parameter int                   ID_WIDTH  = 3,
  parameter logic [ID_WIDTH-1:0]  HDR_ID    = 3'b001,
  parameter logic [ID_WIDTH-1:0]  TAIL_ID   = 3'b100
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_IN-1:0]             req,
  input  logic [NUM_IN*ID_WIDTH-1:0]    flit_id,
  input  logic [NUM_IN*LEN_WIDTH-1:0]   length,
  input  logic                          out_ready,
  output logic [NUM_IN-1:0]             grant,
  output logic [NUM_IN-1:0]             sel,
  output logic                          busy,
  output logic [LEN_WIDTH-1:0]          remaining,
  output logic                          pkt_done
);

  localparam int PTR_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_IN-1:0]    sel_q, sel_d;
  logic [PTR_W-1:0]     owner_q, owner_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [LEN_WIDTH-1:0] remaining_q, remaining_d;
  logic                 pkt_done_q, pkt_done_d;

  logic [NUM_IN-1:0]    eligible;
  logic [NUM_IN-1:0]    is_tail;
  logic [LEN_WIDTH-1:0] len_arr [NUM_IN];

  logic                 win_found;
  logic [PTR_W-1:0]     win_idx;
  int                   scan_idx;

  logic                 owner_req;
  logic                 owner_tail;
  logic                 transfer;
  logic                 release_pkt;

  // Unpack the flattened per-channel fields.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_IN; gi++) begin : g_chan
      assign eligible[gi] = req[gi] && (flit_id[gi*ID_WIDTH +: ID_WIDTH] == HDR_ID);
      assign is_tail[gi]  = (flit_id[gi*ID_WIDTH +: ID_WIDTH] == TAIL_ID);
      assign len_arr[gi]  = length[gi*LEN_WIDTH +: LEN_WIDTH];
    end
  endgenerate

  // Round-robin search: first eligible header starting just after the last owner.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = 0;
    for (int k = 1; k <= NUM_IN; k++) begin
      scan_idx = (int'(ptr_q) + k) % NUM_IN;
      if (!win_found && eligible[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(scan_idx);
      end
    end
  end

  assign owner_req   = |(req & sel_q);
  assign owner_tail  = |(is_tail & sel_q);
  // No flit may leave during a reset cycle, even mid-packet.
  assign transfer    = (state_q == LOCK) && out_ready && owner_req && !rst;
  assign release_pkt = transfer && ((remaining_q == LEN_WIDTH'(1)) || owner_tail);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_found)   state_d = LOCK;
      LOCK:    if (release_pkt) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Lock bookkeeping: owner, flit counter, priority pointer, completion pulse.
  always_comb begin
    sel_d       = sel_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    remaining_d = remaining_q;
    pkt_done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          owner_d = win_idx;
          sel_d   = '0;
          sel_d[win_idx] = 1'b1;
          // A zero length still carries the header flit itself.
          remaining_d = (len_arr[win_idx] == '0) ? LEN_WIDTH'(1) : len_arr[win_idx];
        end else begin
          sel_d       = '0;
          remaining_d = '0;
        end
      end
      LOCK: begin
        if (release_pkt) begin
          sel_d       = '0;
          remaining_d = '0;
          ptr_d       = owner_q;
          pkt_done_d  = 1'b1;
        end else if (transfer && (remaining_q != '0)) begin
          remaining_d = remaining_q - LEN_WIDTH'(1);
        end
      end
      default: begin
        sel_d       = '0;
        remaining_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q       <= '0;
      owner_q     <= '0;
      ptr_q       <= PTR_W'(NUM_IN - 1);
      remaining_q <= '0;
      pkt_done_q  <= 1'b0;
    end else begin
      sel_q       <= sel_d;
      owner_q     <= owner_d;
      ptr_q       <= ptr_d;
      remaining_q <= remaining_d;
      pkt_done_q  <= pkt_done_d;
    end
  end

  // Output logic
  always_comb begin
    grant     = transfer ? sel_q : '0;
    sel       = sel_q;
    busy      = (state_q == LOCK);
    remaining = remaining_q;
    pkt_done  = pkt_done_q;
  end

endmodule

// File: tb/tb_noc_wormhole_arbiter.sv
// Randomized bench for noc_wormhole_arbiter against a packet-level reference model.
module tb_noc_wormhole_arbiter;

  localparam int N  = 5;
  localparam int LW = 12;
  localparam int IW = 3;
  localparam logic [IW-1:0] HDR  = 3'b001;
  localparam logic [IW-1:0] BODY = 3'b010;
  localparam logic [IW-1:0] TAIL = 3'b100;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*IW-1:0] flit_id;
  logic [N*LW-1:0] length;
  logic            out_ready;
  logic [N-1:0]    grant;
  logic [N-1:0]    sel;
  logic            busy;
  logic [LW-1:0]   remaining;
  logic            pkt_done;

  int checks   = 0;
  int failures = 0;

  // Reference model: which channel owns the output and how many flits are left.
  bit m_locked = 1'b0;
  int m_owner  = 0;
  int m_rem    = 0;
  int m_ptr    = N - 1;
  bit m_done   = 1'b0;

  noc_wormhole_arbiter #(
    .NUM_IN(N), .LEN_WIDTH(LW), .ID_WIDTH(IW), .HDR_ID(HDR), .TAIL_ID(TAIL)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .flit_id(flit_id), .length(length),
    .out_ready(out_ready), .grant(grant), .sel(sel), .busy(busy),
    .remaining(remaining), .pkt_done(pkt_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic [N-1:0] rq, input logic [N*IW-1:0] fid,
                      input logic [N*LW-1:0] ln, input logic rdy);
    logic [31:0] exp_grant, exp_sel;
    bit          xfer;
    int          w, idx, len_v;
    @(negedge clk);
    rst = r; req = rq; flit_id = fid; length = ln; out_ready = rdy;
    #1;
    xfer      = !r && m_locked && rdy && rq[m_owner];
    exp_sel   = m_locked ? (32'd1 << m_owner) : 32'd0;
    exp_grant = xfer ? exp_sel : 32'd0;
    check_val("grant", 32'(grant), exp_grant);
    check_val("sel", 32'(sel), exp_sel);
    check_val("busy", 32'(busy), 32'(m_locked));
    check_val("remaining", 32'(remaining), 32'(m_rem));
    check_val("pkt_done", 32'(pkt_done), 32'(m_done));
    $display("cyc t=%0t rst=%0b req=%b rdy=%0b grant=%b sel=%b busy=%0b rem=%0d done=%0b",
             $time, r, rq, rdy, grant, sel, busy, remaining, pkt_done);
    // Advance the model across the coming clock edge.
    m_done = 1'b0;
    if (r) begin
      m_locked = 1'b0; m_rem = 0; m_ptr = N - 1;
    end else if (m_locked) begin
      if (xfer) begin
        if (m_rem == 1 || fid[m_owner*IW +: IW] == TAIL) begin
          m_locked = 1'b0; m_rem = 0; m_ptr = m_owner; m_done = 1'b1;
        end else begin
          m_rem = m_rem - 1;
        end
      end
    end else begin
      w = -1;
      for (int k = 1; k <= N; k++) begin
        idx = (m_ptr + k) % N;
        if (w < 0 && rq[idx] && fid[idx*IW +: IW] == HDR) w = idx;
      end
      if (w >= 0) begin
        len_v    = int'(ln[w*LW +: LW]);
        m_locked = 1'b1;
        m_owner  = w;
        m_rem    = (len_v == 0) ? 1 : len_v;
      end
    end
  endtask

  function automatic logic [N*IW-1:0] all_id(input logic [IW-1:0] id);
    logic [N*IW-1:0] v;
    for (int i = 0; i < N; i++) v[i*IW +: IW] = id;
    return v;
  endfunction

  function automatic logic [N*LW-1:0] all_len(input int l);
    logic [N*LW-1:0] v;
    for (int i = 0; i < N; i++) v[i*LW +: LW] = LW'(l);
    return v;
  endfunction

  logic [N*IW-1:0] fid_r;
  logic [N*LW-1:0] len_r;
  logic [N*IW-1:0] fid_t;
  int              sel_r;

  initial begin
    rst = 1'b1; req = '0; flit_id = '0; length = '0; out_ready = 1'b0;
    step(1'b1, '0, '0, '0, 1'b0);
    step(1'b1, '0, '0, '0, 1'b0);

    // Single packet on ch2, length 4.
    for (int c = 0; c < 7; c++) step(1'b0, 5'b00100, all_id(HDR), all_len(4), 1'b1);
    step(1'b0, '0, '0, '0, 1'b1);

    // Three contenders with length-2 packets.
    for (int c = 0; c < 12; c++) step(1'b0, 5'b01011, all_id(HDR), all_len(2), 1'b1);

    // Everyone requesting: full round-robin sweep.
    for (int c = 0; c < 20; c++) step(1'b0, 5'b11111, all_id(HDR), all_len(2), 1'b1);

    // Stalls mid-packet, then tail cut-short on a long packet.
    for (int c = 0; c < 10; c++) step(1'b0, 5'b00010, all_id(HDR), all_len(6), (c < 2 || c > 4));
    fid_t = all_id(HDR);
    fid_t[4*IW +: IW] = TAIL;
    for (int c = 0; c < 8; c++) step(1'b0, 5'b10000, (c < 3) ? all_id(HDR) : fid_t, all_len(8), 1'b1);

    // Reset mid-packet, zero length, and a body flit that must never win.
    for (int c = 0; c < 3; c++) step(1'b0, 5'b00100, all_id(HDR), all_len(9), 1'b1);
    step(1'b1, 5'b00100, all_id(HDR), all_len(9), 1'b1);
    for (int c = 0; c < 3; c++) step(1'b0, 5'b00101, all_id(HDR), all_len(1), 1'b1);
    fid_t = all_id(HDR);
    fid_t[1*IW +: IW] = BODY;
    for (int c = 0; c < 6; c++) step(1'b0, 5'b01010, fid_t, all_len(0), 1'b1);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        sel_r = int'($urandom_range(0, 9));
        fid_r[i*IW +: IW] = (sel_r < 5) ? HDR : (sel_r < 7) ? BODY : (sel_r < 9) ? TAIL : 3'b000;
        len_r[i*LW +: LW] = ($urandom_range(0, 19) == 0) ? LW'($urandom_range(0, 4095))
                                                          : LW'($urandom_range(0, 6));
      end
      step($urandom_range(0, 49) == 0, N'($urandom), fid_r, len_r, $urandom_range(0, 3) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
